// File: rtl/ctrl_cmd_sequencer.sv
// ============================================================================
// Module      : ctrl_cmd_sequencer
// Description : Round-robin arbiter and mode-transition legality filter that
//               feeds single-cycle one-hot commands to the control-nibble FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_cmd_sequencer #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [3:0]           ctrl_out,
    output logic                 err,
    output logic                 busy,
    output logic [1:0]           cur_mode
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_win, w_win_nxt, r_ptr, w_ptr_nxt;
    logic [3:0]         r_cmd, w_cmd_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [3:0]         r_ctrl, w_ctrl_nxt;
    logic               r_err, w_err_nxt;
    logic               r_busy;
    logic [1:0]         r_mode, w_mode_nxt;

    // Round-robin search: rotate requests so the pointer lands on bit 0,
    // take the lowest set bit, then rotate the offset back.
    logic [2*NUM_REQ-1:0] w_req_rot;
    logic [IDX_W-1:0]     w_off, w_rr_win;
    logic [IDX_W:0]       w_sum;
    logic                 w_found;

    always_comb begin
        w_req_rot = {req, req} >> r_ptr;
        w_off     = '0;
        w_found   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_off   = IDX_W'(k);
                w_found = 1'b1;
            end
        end
        w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
        w_rr_win = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                                  : IDX_W'(w_sum);
    end

    logic [1:0] w_tgt;
    logic       w_tgt_vld, w_tbl_ok, w_legal;

    always_comb begin
        w_tgt     = 2'd0;
        w_tgt_vld = 1'b1;
        case (r_cmd)
            4'b0001: w_tgt = 2'd1;
            4'b0010: w_tgt = 2'd2;
            4'b0100: w_tgt = 2'd3;
            4'b1000: w_tgt = 2'd0;
            default: w_tgt_vld = 1'b0;
        endcase
        case (r_mode)
            2'd0:    w_tbl_ok = (w_tgt == 2'd1) || (w_tgt == 2'd2);
            2'd1:    w_tbl_ok = (w_tgt == 2'd2) || (w_tgt == 2'd0);
            2'd2:    w_tbl_ok = (w_tgt == 2'd3) || (w_tgt == 2'd0);
            default: w_tbl_ok = (w_tgt == 2'd0);
        endcase
        w_legal = w_tgt_vld && w_tbl_ok;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_cmd_nxt   = r_cmd;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_gnt_nxt   = '0;
        w_ctrl_nxt  = 4'b0000;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_win_nxt   = w_rr_win;
                    w_cmd_nxt   = req_cmd[4*w_rr_win +: 4];
                    w_ptr_nxt   = (w_rr_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_rr_win + 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_gnt_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_win;
                if (w_legal) begin
                    w_ctrl_nxt  = r_cmd;
                    w_mode_nxt  = w_tgt;
                    w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
                    w_state_nxt = S_HOLD;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win  <= '0;
            r_cmd  <= 4'b0000;
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_mode <= 2'd0;
            r_gnt  <= '0;
            r_ctrl <= 4'b0000;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_win  <= w_win_nxt;
            r_cmd  <= w_cmd_nxt;
            r_ptr  <= w_ptr_nxt;
            r_cnt  <= w_cnt_nxt;
            r_mode <= w_mode_nxt;
            r_gnt  <= w_gnt_nxt;
            r_ctrl <= w_ctrl_nxt;
            r_err  <= w_err_nxt;
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    assign gnt      = r_gnt;
    assign ctrl_out = r_ctrl;
    assign err      = r_err;
    assign busy     = r_busy;
    assign cur_mode = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_cmd_sequencer.sv
// ============================================================================
// Module      : tb_ctrl_cmd_sequencer
// Description : Directed and random checks of ctrl_cmd_sequencer against a
//               transaction-level model of arbitration and mode legality.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_cmd_sequencer;

    localparam int NP = 4;
    localparam int HC = 3;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     req;
    logic [4*NP-1:0]   req_cmd;
    logic [NP-1:0]     gnt;
    logic [3:0]        ctrl_out;
    logic              err;
    logic              busy;
    logic [1:0]        cur_mode;

    ctrl_cmd_sequencer #(.NUM_REQ(NP), .HOLD_CYCLES(HC)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_cmd  (req_cmd),
        .gnt      (gnt),
        .ctrl_out (ctrl_out),
        .err      (err),
        .busy     (busy),
        .cur_mode (cur_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_ctrl_cyc = 0;
    int last_err_cyc  = 0;

    // Reference model state: tracked mode and round-robin start point
    int m_mode = 0;
    int m_ptr  = 0;
    bit legal_tbl [4][4];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int target_of(input logic [3:0] c);
        case (c)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 3;
            4'b1000: return 0;
            default: return -1;
        endcase
    endfunction

    task automatic check_quiet(input string tag, input logic exp_busy);
        chk({tag, "_gnt"},  32'(gnt), 32'd0);
        chk({tag, "_ctrl"}, 32'(ctrl_out), 32'd0);
        chk({tag, "_err"},  32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    // One complete arbitration: apply, check ISSUE cycle, grant cycle, hold window
    task automatic run_txn(input logic [NP-1:0] rv, input logic [4*NP-1:0] cv,
                           input bit drop, input bit keep, input int exp_space);
        int w;
        int t;
        bit ok;
        logic [3:0] c;
        w = -1;
        for (int k = 0; k < NP; k++) begin
            if (w < 0 && rv[(m_ptr + k) % NP]) w = (m_ptr + k) % NP;
        end
        c  = cv[4*w +: 4];
        t  = target_of(c);
        ok = (t >= 0) && legal_tbl[m_mode][t];

        req     = rv;
        req_cmd = cv;
        tick();
        check_quiet("issue", 1'b1);
        chk("issue_mode", 32'(cur_mode), 32'(m_mode));
        if (drop) req[w] = 1'b0;
        req_cmd = (4*NP)'($urandom);
        tick();
        if (ok) m_mode = t;
        m_ptr = (w + 1) % NP;
        chk("gnt",  32'(gnt), 32'(1) << w);
        chk("ctrl", 32'(ctrl_out), ok ? 32'(c) : 32'd0);
        chk("err",  32'(err), ok ? 32'd0 : 32'd1);
        chk("mode", 32'(cur_mode), 32'(m_mode));
        if (exp_space > 0) begin
            if (ok) chk("ctrl_spacing", 32'(cyc - last_ctrl_cyc), 32'(exp_space));
            else    chk("err_spacing",  32'(cyc - last_err_cyc),  32'(exp_space));
        end
        if (ok) last_ctrl_cyc = cyc;
        else    last_err_cyc  = cyc;
        req     = keep ? rv : '0;
        req_cmd = cv;
        chk("busy_after_issue", 32'(busy), ok ? 32'd1 : 32'd0);
        if (ok) begin
            for (int h = 1; h < HC; h++) begin
                tick();
                check_quiet("hold", 1'b1);
            end
            tick();
            check_quiet("hold_end", 1'b0);
        end
    endtask

    function automatic logic [4*NP-1:0] one_cmd(input int slot, input logic [3:0] c);
        logic [4*NP-1:0] v;
        v = '0;
        v[4*slot +: 4] = c;
        return v;
    endfunction

    function automatic logic [3:0] rand_cmd();
        logic [3:0] v;
        if ($urandom_range(3) != 0) v = 4'b0001 << $urandom_range(3);
        else                        v = 4'($urandom);
        return v;
    endfunction

    initial begin
        logic [NP-1:0]   rv;
        logic [4*NP-1:0] cv;

        foreach (legal_tbl[i, j]) legal_tbl[i][j] = 1'b0;
        legal_tbl[0][1] = 1'b1; legal_tbl[0][2] = 1'b1;
        legal_tbl[1][2] = 1'b1; legal_tbl[1][0] = 1'b1;
        legal_tbl[2][3] = 1'b1; legal_tbl[2][0] = 1'b1;
        legal_tbl[3][0] = 1'b1;

        rst = 1'b1; req = '0; req_cmd = '0;
        tick(); tick();
        check_quiet("reset", 1'b0);
        chk("reset_mode", 32'(cur_mode), 32'd0);
        rst = 1'b0;
        tick();
        check_quiet("post_reset", 1'b0);

        // Single legal request, then back to BASE
        run_txn(4'b0001, one_cmd(0, 4'b0001), 1'b0, 1'b0, -1);
        run_txn(4'b0001, one_cmd(0, 4'b1000), 1'b0, 1'b0, HC + 2);

        // Legal chain from requester 2, back-to-back
        run_txn(4'b0100, one_cmd(2, 4'b0010), 1'b0, 1'b0, HC + 2);
        run_txn(4'b0100, one_cmd(2, 4'b0100), 1'b0, 1'b0, HC + 2);
        run_txn(4'b0100, one_cmd(2, 4'b1000), 1'b0, 1'b0, HC + 2);

        // Rejections from BASE; requester 3 leaves the pointer at 0
        run_txn(4'b1000, one_cmd(3, 4'b0100), 1'b0, 1'b0, -1);
        run_txn(4'b1000, one_cmd(3, 4'b0011), 1'b0, 1'b0, 2);
        run_txn(4'b1000, one_cmd(3, 4'b0000), 1'b0, 1'b0, 2);

        // Contention: all requesters post an illegal self-transition
        for (int n = 0; n < 5; n++) begin
            run_txn(4'b1111, {4{4'b1000}}, 1'b0, 1'b1, 2);
            chk("rr_order", 32'(gnt), 32'(1) << (n % NP));
        end
        req = '0;
        tick();

        // Reset during the second hold cycle
        req = 4'b0001; req_cmd = one_cmd(0, 4'b0001);
        tick();
        tick();
        chk("pre_rst_ctrl", 32'(ctrl_out), 32'd1);
        req = '0;
        tick();
        rst = 1'b1;
        tick();
        check_quiet("mid_hold_rst", 1'b0);
        chk("mid_hold_rst_mode", 32'(cur_mode), 32'd0);
        rst = 1'b0;
        m_mode = 0;
        m_ptr  = 0;
        run_txn(4'b1000, one_cmd(3, 4'b0001), 1'b0, 1'b0, -1);

        // Request dropped after being latched
        run_txn(4'b0010, one_cmd(1, 4'b0010), 1'b1, 1'b0, -1);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            rv = NP'($urandom);
            for (int s = 0; s < NP; s++) cv[4*s +: 4] = rand_cmd();
            if (rv == '0) begin
                req = '0; req_cmd = cv;
                tick();
                check_quiet("idle", 1'b0);
            end else begin
                run_txn(rv, cv, 1'($urandom), 1'b0, -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ctrl_cmd_sequencer.md
Name: ctrl_cmd_sequencer

Overview:
- Round-robin arbiter and legality filter placed in front of the control-nibble state machine.
- Several requesters each post a 4-bit one-hot control command. The block grants one requester at a time and checks the command against a fixed mode-transition table.
- A legal command is forwarded as a single-cycle pulse on ctrl_out, followed by a mandatory quiet (hold) window.
- The downstream state machine never sees multi-hot codes, back-to-back codes or out-of-sequence jumps.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 3, number of quiet cycles after each issued command (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  per-requester request; held until that requester's gnt.
- req_cmd  input  4*NUM_REQ  command of requester i in bits [4i+3:4i].
- gnt  output  NUM_REQ  one-cycle grant pulse to the serviced requester.
- ctrl_out  output  4  command to the state machine; one-hot pulse or 4'b0000.
- err  output  1  one-cycle pulse when the serviced command is rejected.
- busy  output  1  high whenever the FSM is not in IDLE.
- cur_mode  output  2  tracked mode: 0=BASE, 1=A, 2=B, 3=C.

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset (highest priority, also mid-operation): state=IDLE, gnt=0, ctrl_out=0, err=0, busy=0, cur_mode=BASE, RR pointer=0, hold counter=0. Any in-flight command is discarded.
- Command codes:
  - 4'b0001 targets A.
  - 4'b0010 targets B.
  - 4'b0100 targets C.
  - 4'b1000 targets BASE.
  - Any other value (zero or multi-hot) is illegal.
- Legal transitions:
  - BASE->A, BASE->B.
  - A->B, A->BASE.
  - B->C, B->BASE.
  - C->BASE only.
  - A self-transition (target == cur_mode) is illegal.
- FSM states IDLE, ISSUE, HOLD:
  - IDLE: at an edge where any req is high, pick the winner by round-robin. Search starts at the RR pointer and ascends with wrap. Latch the winner index and its req_cmd, then go to ISSUE. RR pointer <= (winner+1) mod NUM_REQ. No req: stay in IDLE.
  - ISSUE (one cycle): at its closing edge gnt[winner]<=1.
    - Legal command: ctrl_out<=cmd, cur_mode<=target, hold counter<=HOLD_CYCLES-1, go to HOLD.
    - Illegal command: err<=1, ctrl_out<=0, cur_mode unchanged, go to IDLE (no hold).
  - HOLD: gnt, ctrl_out and err return to 0 at the first edge. Counter decrements each edge. When the counter is 0, go to IDLE. HOLD lasts exactly HOLD_CYCLES cycles.
- Latency: req sampled at edge E0 -> gnt/ctrl_out high for exactly the one cycle after edge E1.
- Minimum spacing between two ctrl_out pulses is HOLD_CYCLES+2 cycles.
- Minimum spacing between two err pulses is 2 cycles.
- req/req_cmd are ignored outside IDLE.
- A req deasserted after it is latched is still serviced, and its gnt is still pulsed.
- req_cmd changes after latching have no effect.
- gnt is never asserted to more than one requester; gnt, ctrl_out and err are never high outside the post-ISSUE cycle.
- ctrl_out is always either one-hot or zero.
- busy=1 in ISSUE and HOLD.

Test Plan:
- Reset then single request, req[0]=1 with cmd 4'b0001 at edge E0 -> gnt[0]=1 and ctrl_out=4'b0001 in the cycle after E1, cur_mode=1, busy=1 for 1+3 cycles, err=0.
- Legal sequence from requester 2 (0010, then 0100, then 1000) -> ctrl_out pulses 0010, 0100, 1000, spaced exactly 5 cycles apart; cur_mode goes 2, 3, 0.
- Illegal commands:
  - From BASE, cmd 4'b0100 -> gnt pulse + err=1, ctrl_out=0, cur_mode stays 0, next request accepted 2 cycles later.
  - Cmd 4'b0011 -> same rejection.
  - Cmd 4'b0000 -> same rejection.
- Contention: all 4 req high continuously, each posting 4'b1000 from BASE (illegal self) -> gnt order 0, 1, 2, 3, 0 with err pulses every 2 cycles; fairness holds across the wrap.
- Reset mid-HOLD (rst=1 on the second HOLD cycle, after a 0001 issue) -> next edge: busy=0, cur_mode=0, ctrl_out=0; a following req[3] with 0001 is granted first via the reset pointer search (pointer=0, only req[3] active).
- Request dropped after latch: req[1] high for a single cycle with cmd 0010 -> gnt[1] still pulses, ctrl_out=0010.
